// File: rtl/serial_to_parallel_rx.sv
// rtl/serial_to_parallel_rx.sv - MSB-first serial-to-parallel word receiver with valid/ready output
//
// Collects one bit per qualified clock into WIDTH-bit words and presents each
// completed word through a single holding register with sticky overrun.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   serial_in    in   serial data bit, sampled when bit_valid=1
//   bit_valid    in   qualifies serial_in on this edge
//   frame_sync   in   realign: discard partial word (this bit starts a new word)
//   out_ready    in   downstream accepts data_out this cycle
//   overrun_clr  in   clears sticky overrun
//   data_out     out  last completed word
//   out_valid    out  data_out holds an unaccepted word
//   busy         out  partial word in progress
//   overrun      out  sticky: a completed word was dropped

module serial_to_parallel_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_sync,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             can_load;

    // frame_sync outranks completion: a partial word is never delivered.
    assign word      = {sr[WIDTH-2:0], serial_in};
    assign word_done = bit_valid && !frame_sync && (cnt == CNT_MAX);
    assign can_load  = !out_valid || out_ready;
    assign busy      = (cnt != '0);

    // The shift happens on every qualified bit, including the realigning one;
    // stale upper bits are pushed out before the new word completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (bit_valid) begin
            sr <= word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (frame_sync) begin
            cnt <= bit_valid ? CNT_ONE : '0;
        end else if (bit_valid) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (word_done && can_load) begin
            data_out  <= word;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready && !word_done) begin
            out_valid <= 1'b0;
        end
    end

    // A drop on the same edge as a clear must remain visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (word_done && !can_load) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb/tb_serial_to_parallel_rx.sv - self-checking bench for serial_to_parallel_rx

module tb_serial_to_parallel_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         serial_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic         out_ready = 1'b0;
    logic         overrun_clr = 1'b0;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the received bits of the partial word as a queue,
    // plus the holding register contents.
    bit           q_bits[$];
    logic [W-1:0] m_data = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;

    serial_to_parallel_rx #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .serial_in(serial_in),
        .bit_valid(bit_valid),
        .frame_sync(frame_sync),
        .out_ready(out_ready),
        .overrun_clr(overrun_clr),
        .data_out(data_out),
        .out_valid(out_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(q_bits.size() != 0));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic model_step(input bit sv, input bit bv, input bit fs, input bit rdy, input bit clr);
        bit           done = 0;
        bit           drop = 0;
        logic [W-1:0] w = '0;
        if (fs) begin
            q_bits.delete();
            if (bv) q_bits.push_back(sv);
        end else if (bv) begin
            q_bits.push_back(sv);
            if (q_bits.size() == W) begin
                done = 1;
                for (int i = 0; i < W; i++) if (q_bits[i]) w = w + (W'(1) << (W - 1 - i));
                q_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = w;
                m_valid = 1'b1;
            end else begin
                drop = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic cycle(input bit sv, input bit bv, input bit fs, input bit rdy, input bit clr);
        serial_in   = sv;
        bit_valid   = bv;
        frame_sync  = fs;
        out_ready   = rdy;
        overrun_clr = clr;
        @(posedge clk);
        #1;
        model_step(sv, bv, fs, rdy, clr);
        check_model();
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap, input bit rdy, input bit rdy_last);
        for (int i = W - 1; i >= 0; i--) begin
            cycle(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy, 1'b0);
            if (i != 0) for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, rdy, 1'b0);
        end
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        q_bits.delete();
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] junk;
        // Reset state
        async_reset();

        // Back-to-back word with ready held high
        send_word(8'hA5, 0, 1'b1, 1'b1);
        chk("a5_valid", 32'(out_valid), 32'h1);
        chk("a5_data", 32'(data_out), 32'hA5);
        chk("a5_busy", 32'(busy), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("a5_valid_drop", 32'(out_valid), 32'h0);

        // Gapped bits
        send_word(8'h3C, 1, 1'b1, 1'b1);
        chk("3c_data", 32'(data_out), 32'h3C);
        chk("3c_valid", 32'(out_valid), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-pressure and overrun
        send_word(8'h11, 0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b0);
        chk("bp_data", 32'(data_out), 32'h11);
        chk("bp_overrun", 32'(overrun), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_clr", 32'(overrun), 32'h0);
        chk("bp_still_valid", 32'(out_valid), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_accept", 32'(out_valid), 32'h0);

        // Simultaneous accept and complete
        send_word(8'h11, 0, 1'b0, 1'b0);
        send_word(8'h22, 0, 1'b0, 1'b1);
        chk("sim_data", 32'(data_out), 32'h22);
        chk("sim_valid", 32'(out_valid), 32'h1);
        chk("sim_overrun", 32'(overrun), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Realignment after junk bits
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        junk = 8'hC3;
        cycle(junk[7], 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 6; i >= 0; i--) cycle(junk[i], 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sync_data", 32'(data_out), 32'hC3);
        chk("sync_valid", 32'(out_valid), 32'h1);
        chk("sync_overrun", 32'(overrun), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // frame_sync on the 8th bit: nothing delivered
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sync8_valid", 32'(out_valid), 32'h0);
        chk("sync8_overrun", 32'(overrun), 32'h0);
        chk("sync8_busy", 32'(busy), 32'h1);

        // Reset mid-word
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        async_reset();
        send_word(8'hFF, 0, 1'b1, 1'b1);
        chk("ff_data", 32'(data_out), 32'hFF);
        chk("ff_valid", 32'(out_valid), 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
